// File: rtl/spi_rx.sv
// rtl/spi_rx.sv - SPI receiver: synchronized sclk/mosi/frame, MSB-first word capture, valid/ready output
// Overflow is sticky; frame_err pulses when a frame ends partway through a word.
module spi_rx #(
   parameter int WIDTH = 32,
   parameter int SYNC  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk,
   input  logic             mosi,
   input  logic             frame,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   input  logic             ready,
   output logic             overflow,
   input  logic             clr_ovf,
   output logic             frame_err
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_next;
   logic [SYNC-1:0]  sclk_sync, mosi_sync, frame_sync;
   logic             sclk_prev;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-2:0] shreg;
   logic [WIDTH-1:0] full_word;
   logic             sclk_s, mosi_s, frame_s, sclk_rise;
   logic             shift_en, cnt_clr, word_done, err_next;

   // Equal-depth chains keep sclk, mosi and frame aligned cycle for cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync  <= '0;
         mosi_sync  <= '0;
         frame_sync <= '0;
         sclk_prev  <= 1'b0;
      end else begin
         sclk_sync  <= {sclk_sync[SYNC-2:0], sclk};
         mosi_sync  <= {mosi_sync[SYNC-2:0], mosi};
         frame_sync <= {frame_sync[SYNC-2:0], frame};
         sclk_prev  <= sclk_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC-1];
   assign mosi_s    = mosi_sync[SYNC-1];
   assign frame_s   = frame_sync[SYNC-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign full_word = {shreg, mosi_s};

   always_comb begin
      state_next = state;
      shift_en   = 1'b0;
      cnt_clr    = 1'b0;
      word_done  = 1'b0;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (frame_s) state_next = SHIFT;
         end
         SHIFT: begin
            if (!frame_s) begin
               state_next = IDLE;
               err_next   = (bit_cnt != '0);
            end else if (sclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == CW'(WIDTH - 1)) begin
                  word_done  = 1'b1;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (!frame_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_next;
         frame_err <= err_next;
         if (cnt_clr) begin
            bit_cnt <= '0;
            shreg   <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + CW'(1);
            shreg   <= full_word[WIDTH-2:0];
         end
      end
   end

   // A completing word loads if the holding register is free or being consumed this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (word_done && (!valid || ready)) begin
            data_out <= full_word;
            valid    <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         if (word_done && valid && !ready) overflow <= 1'b1;
         else if (clr_ovf)                 overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_rx.sv
// tb/tb_spi_rx.sv - randomized bench for spi_rx against a word-level reference model
module tb_spi_rx;

   localparam int WIDTH = 32;
   localparam int SYNC  = 2;

   logic             clk = 1'b0;
   logic             reset, sclk, mosi, frame, ready, clr_ovf;
   logic [WIDTH-1:0] data_out;
   logic             valid, overflow, frame_err;

   int               n_checks = 0;
   int               n_pass   = 0;
   int               err_cycles = 0;

   logic [31:0]      exp_data;
   logic             exp_valid, exp_ovf;

   spi_rx #(.WIDTH(WIDTH), .SYNC(SYNC)) dut (
      .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .frame(frame),
      .data_out(data_out), .valid(valid), .ready(ready),
      .overflow(overflow), .clr_ovf(clr_ovf), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_err) err_cycles++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // n rising sclk edges at 8 clk per period; mosi changes with the falling edge.
   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         mosi = (i < 32) ? w[31-i] : 1'b0;
         wait_clk(4);
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
   endtask

   // Full frame plus model update: only the first 32 edges of a frame form a word.
   task automatic run_frame(input string tag, input logic [31:0] w, input int n);
      int e0;
      e0 = err_cycles;
      frame = 1'b1;
      wait_clk(4);
      send_bits(w, n);
      wait_clk(4);
      frame = 1'b0;
      wait_clk(SYNC + 4);
      if (n >= WIDTH) begin
         if (exp_valid) exp_ovf = 1'b1;
         else begin
            exp_data  = w;
            exp_valid = 1'b1;
         end
      end
      check({tag, " frame_err"}, err_cycles - e0, (n > 0 && n < WIDTH) ? 1 : 0);
      check({tag, " data_out"}, data_out, exp_data);
      check({tag, " valid"}, {31'd0, valid}, {31'd0, exp_valid});
      check({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
   endtask

   task automatic pulse_ready(input string tag);
      ready = 1'b1;
      wait_clk(1);
      ready = 1'b0;
      if (exp_valid) exp_valid = 1'b0;
      check({tag, " valid"}, {31'd0, valid}, {31'd0, exp_valid});
      check({tag, " data_out"}, data_out, exp_data);
   endtask

   task automatic pulse_clr(input string tag);
      clr_ovf = 1'b1;
      wait_clk(1);
      clr_ovf = 1'b0;
      exp_ovf = 1'b0;
      check({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
   endtask

   task automatic do_reset(input logic keep_frame);
      reset = 1'b1;
      frame = keep_frame;
      sclk  = 1'b0;
      wait_clk(2);
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      check("rst data_out", data_out, 32'd0);
      check("rst flags", {29'd0, valid, overflow, frame_err}, 32'd0);
      reset = 1'b0;
      wait_clk(1);
   endtask

   initial begin
      int e0, n, r;
      logic [31:0] w;
      reset = 1'b1; sclk = 1'b0; mosi = 1'b0; frame = 1'b0; ready = 1'b0; clr_ovf = 1'b0;
      exp_data = '0; exp_valid = 1'b0; exp_ovf = 1'b0;
      do_reset(1'b0);

      run_frame("basic", 32'hA5C3_0F1E, 32);
      pulse_ready("consume");
      run_frame("ovf1", 32'h0000_0001, 32);
      run_frame("ovf2", 32'hFFFF_FFFF, 32);
      pulse_clr("clr_ovf");
      pulse_ready("consume2");
      run_frame("short13", 32'hCAFE_F00D, 13);
      run_frame("after_short", 32'h1234_5678, 32);
      pulse_ready("consume3");
      run_frame("long40", 32'hDEAD_BEEF, 40);
      run_frame("empty", 32'h0, 0);

      // Reset in the middle of a frame: no frame_err, model cleared.
      e0 = err_cycles;
      frame = 1'b1;
      wait_clk(4);
      send_bits(32'h5555_AAAA, 20);
      do_reset(1'b1);
      frame = 1'b0;
      wait_clk(SYNC + 4);
      check("midreset frame_err", err_cycles - e0, 0);
      run_frame("post_reset", 32'h8000_0000, 32);
      pulse_ready("consume4");

      // Frame already high across reset release is taken as a new frame.
      do_reset(1'b1);
      wait_clk(4);
      send_bits(32'h0F0F_3C3C, 32);
      wait_clk(4);
      frame = 1'b0;
      wait_clk(SYNC + 4);
      exp_data = 32'h0F0F_3C3C; exp_valid = 1'b1;
      check("held data_out", data_out, exp_data);
      check("held valid", {31'd0, valid}, {31'd0, exp_valid});

      for (int k = 0; k < 24; k++) begin
         w = $urandom;
         r = $urandom_range(0, 9);
         n = (r < 6) ? 32 : (r < 8) ? $urandom_range(1, 31) : $urandom_range(33, 36);
         run_frame($sformatf("rnd%0d", k), w, n);
         if ($urandom_range(0, 2) != 0) pulse_ready($sformatf("rnd%0d rdy", k));
         if ($urandom_range(0, 3) == 0) pulse_clr($sformatf("rnd%0d clr", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
